// File: rtl/write_fifo_rr.sv
// Round-robin merge of CH single-beat AXI write requesters into one AXI4-MM write port through a DEPTH-entry FIFO.
// Optional B-response routing back to the requesting channel: define WRITE_FIFO_BRESP_ROUTE_EN.
module write_fifo_rr #(
    parameter int CH     = 1,
    parameter int DEPTH  = 16,
    parameter int DATA_W = 512,
    parameter int ADDR_W = 64,
    parameter int ID_W   = 12,
    parameter int USER_W = 6
) (
    input  logic                    axi4_mm_clk,
    input  logic                    axi4_mm_rst_n,

    input  logic [CH-1:0]           awvalid_ch,
    output logic [CH-1:0]           awready_ch,
    input  logic [ADDR_W-1:0]       awaddr_ch  [CH],
    input  logic [ID_W-1:0]         awid_ch    [CH],
    input  logic [USER_W-1:0]       awuser_ch  [CH],
    input  logic [CH-1:0]           wvalid_ch,
    output logic [CH-1:0]           wready_ch,
    input  logic [DATA_W-1:0]       wdata_ch   [CH],
    input  logic [DATA_W/8-1:0]     wstrb_ch   [CH],
    input  logic [CH-1:0]           wlast_ch,
    output logic [CH-1:0]           bvalid_ch,
    output logic [1:0]              bresp_ch   [CH],
    output logic [ID_W-1:0]         bid_ch     [CH],

    output logic                    awvalid,
    input  logic                    awready,
    output logic [ADDR_W-1:0]       awaddr,
    output logic [ID_W-1:0]         awid,
    output logic [USER_W-1:0]       awuser,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [DATA_W-1:0]       wdata,
    output logic [DATA_W/8-1:0]     wstrb,
    output logic                    wlast,

    input  logic                    bvalid,
    input  logic [ID_W-1:0]         bid,
    input  logic [1:0]              bresp,
    output logic                    bready,

    output logic [$clog2(DEPTH):0]  fill_level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int SRC_W = (CH > 1) ? $clog2(CH) : 1;

    logic [CNT_W-1:0]    w_ptr;
    logic [CNT_W-1:0]    r_ptr;
    logic [CNT_W-1:0]    cnt;
    logic                empty;
    logic                full;
    logic                rst_done;
    logic [SRC_W-1:0]    rr_ptr;
    logic                aw_done;
    logic                w_done;

    logic [CH-1:0]       eligible;
    logic                grant_found;
    logic [SRC_W-1:0]    grant_idx;
    logic                push;
    logic                aw_hs;
    logic                w_hs;
    logic                pop;
    logic [ID_W-1:0]     push_id;

    logic [ADDR_W-1:0]   mem_addr [DEPTH];
    logic [ID_W-1:0]     mem_id   [DEPTH];
    logic [USER_W-1:0]   mem_user [DEPTH];
    logic [DATA_W-1:0]   mem_data [DEPTH];
    logic [DATA_W/8-1:0] mem_strb [DEPTH];
    logic                mem_last [DEPTH];

    logic [AW-1:0]       head;
    logic [AW-1:0]       tail;

    assign cnt        = w_ptr - r_ptr;
    assign empty      = (w_ptr == r_ptr);
    assign full       = (cnt == CNT_W'(DEPTH));
    assign fill_level = cnt;
    assign head       = r_ptr[AW-1:0];
    assign tail       = w_ptr[AW-1:0];
    assign eligible   = awvalid_ch & wvalid_ch;

    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < CH; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= CH) begin
                idx = idx - CH;
            end
            if (!grant_found && eligible[idx]) begin
                grant_found = 1'b1;
                grant_idx   = SRC_W'(idx);
            end
        end
    end

    // Accept is held off until the first clock after reset release, and never while full.
    assign push = rst_done && !full && grant_found;

    always_comb begin
        awready_ch = '0;
        wready_ch  = '0;
        for (int i = 0; i < CH; i++) begin
            if (push && (int'(grant_idx) == i)) begin
                awready_ch[i] = 1'b1;
                wready_ch[i]  = 1'b1;
            end
        end
    end

    assign awvalid = !empty && !aw_done;
    assign wvalid  = !empty && !w_done;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign pop     = !empty && (aw_done || aw_hs) && (w_done || w_hs);

    always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
        if (!axi4_mm_rst_n) begin
            w_ptr    <= '0;
            r_ptr    <= '0;
            rr_ptr   <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            if (push) begin
                w_ptr  <= w_ptr + 1'b1;
                rr_ptr <= (grant_idx == SRC_W'(CH - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (pop) begin
                r_ptr   <= r_ptr + 1'b1;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
        end
    end

`ifdef WRITE_FIFO_BRESP_ROUTE_EN
    // Source channel is carried in the top awid bits so the B response can find its way home.
    logic [SRC_W-1:0] b_src;
    logic             unused_awid_hi;

    always_comb begin
        push_id = {grant_idx, awid_ch[grant_idx][ID_W-SRC_W-1:0]};
    end

    always_comb begin
        unused_awid_hi = 1'b0;
        for (int i = 0; i < CH; i++) begin
            unused_awid_hi = unused_awid_hi ^ (^awid_ch[i][ID_W-1 -: SRC_W]);
        end
    end

    assign b_src = bid[ID_W-1 -: SRC_W];

    always_comb begin
        bvalid_ch = '0;
        for (int i = 0; i < CH; i++) begin
            bresp_ch[i] = '0;
            bid_ch[i]   = '0;
            if (bvalid && (int'(b_src) == i)) begin
                bvalid_ch[i] = 1'b1;
                bresp_ch[i]  = bresp;
                bid_ch[i]    = {{SRC_W{1'b0}}, bid[ID_W-SRC_W-1:0]};
            end
        end
    end
`else
    logic unused_b;

    always_comb begin
        push_id = awid_ch[grant_idx];
    end

    assign unused_b = ^{bvalid, bid, bresp};

    always_comb begin
        bvalid_ch = '0;
        for (int i = 0; i < CH; i++) begin
            bresp_ch[i] = '0;
            bid_ch[i]   = '0;
        end
    end
`endif

    assign bready = 1'b1;

    always_ff @(posedge axi4_mm_clk) begin
        if (push) begin
            mem_addr[tail] <= awaddr_ch[grant_idx];
            mem_id[tail]   <= push_id;
            mem_user[tail] <= awuser_ch[grant_idx];
            mem_data[tail] <= wdata_ch[grant_idx];
            mem_strb[tail] <= wstrb_ch[grant_idx];
            mem_last[tail] <= wlast_ch[grant_idx];
        end
    end

    assign awaddr = mem_addr[head];
    assign awid   = mem_id[head];
    assign awuser = mem_user[head];
    assign wdata  = mem_data[head];
    assign wstrb  = mem_strb[head];
    assign wlast  = mem_last[head];

endmodule
